// File: rtl/display_pkg.sv
// display_pkg: shared types, segment table and slot-length helper for the display scheduler
package display_pkg;

   typedef enum logic [1:0] {
      SHOW_HI = 2'd0,
      GAP_HI  = 2'd1,
      SHOW_LO = 2'd2,
      GAP_LO  = 2'd3
   } state_t;

   // Hex digit to segments {g,f,e,d,c,b,a}, 1 = lit
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic int slot_cycles(input int clk_hz, input int refresh_hz);
      return clk_hz / (2 * refresh_hz);
   endfunction

endpackage

// File: rtl/hex_to_segments.sv
// hex_to_segments: combinational nibble to 7-segment lookup
module hex_to_segments
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: tear-free time-multiplexed driver for a dual 7-segment display
module display_scheduler
   import display_pkg::*;
#(
   parameter int CLK_HZ        = 12_000_000,
   parameter int REFRESH_HZ    = 100,
   parameter int GAP_CYCLES    = 16,
   parameter int BLANK_LEADING = 0
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       blank,
   output logic [6:0] led_port,
   output logic       c,
   output logic       frame_done
);

   localparam int SLOT = slot_cycles(CLK_HZ, REFRESH_HZ);
   localparam int CW = $clog2(SLOT);
   localparam logic [CW-1:0] LAST = CW'(SLOT - 1);
   localparam logic [CW-1:0] SHOW_END = CW'(SLOT - GAP_CYCLES - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [7:0]      disp;
   logic [7:0]      pend;
   logic            pend_v;
   logic            hi;
   logic            show;
   logic            advance;
   logic            boundary;
   logic            lead_off;
   logic [3:0]      nibble;
   logic [6:0]      seg;
   logic [6:0]      led_next;

   assign in_ready = !pend_v;
   assign hi       = state == SHOW_HI || state == GAP_HI;
   assign show     = state == SHOW_HI || state == SHOW_LO;
   assign advance  = show ? cnt == SHOW_END : cnt == LAST;
   assign boundary = state == GAP_LO && cnt == LAST;
   assign nibble   = hi ? disp[7:4] : disp[3:0];
   assign lead_off = BLANK_LEADING != 0 && hi && disp[7:4] == 4'h0;
   assign led_next = (blank || !show || lead_off) ? 7'h00 : seg;

   hex_to_segments u_lut (
      .nibble(nibble),
      .seg   (seg)
   );

   // Slot sequencer; outputs are registered so they trail the state by one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= SHOW_HI;
         cnt        <= '0;
         led_port   <= 7'h00;
         c          <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         cnt        <= cnt == LAST ? '0 : cnt + CW'(1);
         state      <= advance ? state_t'(state + 2'd1) : state;
         led_port   <= led_next;
         c          <= hi;
         frame_done <= boundary;
      end
   end

   // Pending/display handoff; new values only reach disp at a frame boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp   <= 8'h00;
         pend   <= 8'h00;
         pend_v <= 1'b0;
      end else if (boundary && pend_v) begin
         disp   <= pend;
         pend_v <= 1'b0;
      end else if (in_valid && !pend_v) begin
         pend   <= in_data;
         pend_v <= 1'b1;
      end
   end

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: vector table, directed corner cases and random traffic against a frame-position model
module tb_display_scheduler;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       b;
      logic [6:0] led;
      logic       c;
      logic       fd;
   } vec_t;

   localparam logic [6:0] LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       vin [2];
   logic [7:0] din [2];
   logic       bin [2];
   logic       rdy [2];
   logic       c_o [2];
   logic       fd [2];
   logic [6:0] led [2];

   int checks = 0;
   int failures = 0;
   int m_n = 0;
   logic [7:0] m_disp [2];
   logic [7:0] m_pend [2];
   logic       m_pv [2];

   vec_t tbl [40];

   always #5 clk = ~clk;

   display_scheduler #(.CLK_HZ(1000), .REFRESH_HZ(50), .GAP_CYCLES(2), .BLANK_LEADING(0)) dut0 (
      .clk(clk), .reset(reset), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
      .blank(bin[0]), .led_port(led[0]), .c(c_o[0]), .frame_done(fd[0])
   );

   display_scheduler #(.CLK_HZ(1000), .REFRESH_HZ(50), .GAP_CYCLES(2), .BLANK_LEADING(1)) dut1 (
      .clk(clk), .reset(reset), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
      .blank(bin[1]), .led_port(led[1]), .c(c_o[1]), .frame_done(fd[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, m_n);
      end
   endtask

   // Frame is 20 cycles: positions 0..9 left digit (8 lit, 2 gap), 10..19 right digit
   function automatic logic [6:0] model_led(input int i, input int pos);
      logic [3:0] nib;
      nib = pos < 10 ? m_disp[i][7:4] : m_disp[i][3:0];
      if (bin[i] || pos % 10 >= 8 || (i == 1 && pos < 10 && nib == 4'h0)) return 7'h00;
      return LUT[nib];
   endfunction

   task automatic tick();
      int pos;
      logic [6:0] el [2];
      pos = m_n % 20;
      for (int i = 0; i < 2; i++) begin
         el[i] = model_led(i, pos);
         if (pos == 19 && m_pv[i]) begin
            m_disp[i] = m_pend[i];
            m_pv[i] = 1'b0;
         end else if (vin[i] && !m_pv[i]) begin
            m_pend[i] = din[i];
            m_pv[i] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      m_n++;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("led%0d", i), led[i], el[i]);
         chk($sformatf("c%0d", i), c_o[i], pos < 10);
         chk($sformatf("frame_done%0d", i), fd[i], pos == 19);
         chk($sformatf("in_ready%0d", i), rdy[i], !m_pv[i]);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_led", led[i], 0);
         chk("rst_c", c_o[i], 1);
         chk("rst_in_ready", rdy[i], 1);
         chk("rst_frame_done", fd[i], 0);
      end
      @(negedge clk);
      reset = 1'b0;
      m_n = 0;
      for (int i = 0; i < 2; i++) begin
         m_disp[i] = 8'h00;
         m_pend[i] = 8'h00;
         m_pv[i] = 1'b0;
      end
   endtask

   initial begin
      vec_t s_hi, g_hi, s_lo, g_lo, f_lo, b_lo;
      s_hi = '{1'b0, 8'h00, 1'b0, 7'h3F, 1'b1, 1'b0};
      g_hi = '{1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 1'b0};
      s_lo = '{1'b0, 8'h00, 1'b0, 7'h3F, 1'b0, 1'b0};
      g_lo = '{1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0};
      f_lo = '{1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1};
      b_lo = '{1'b0, 8'h00, 1'b1, 7'h00, 1'b0, 1'b0};
      tbl = '{s_hi, s_hi, s_hi, s_hi, s_hi, s_hi, s_hi, s_hi, g_hi, g_hi,
              s_lo, s_lo, s_lo, s_lo, s_lo, s_lo, s_lo, s_lo, g_lo, f_lo,
              s_hi, s_hi, s_hi, s_hi, s_hi, s_hi, s_hi, s_hi, g_hi, g_hi,
              s_lo, s_lo, b_lo, b_lo, b_lo, b_lo, b_lo, s_lo, g_lo, f_lo};
      for (int i = 0; i < 2; i++) begin
         vin[i] = 1'b0;
         din[i] = 8'h00;
         bin[i] = 1'b0;
      end
      #2;
      do_reset();

      for (int k = 0; k < 40; k++) begin
         vin[0] = tbl[k].v;
         din[0] = tbl[k].d;
         bin[0] = tbl[k].b;
         tick();
         chk("tbl_led", led[0], tbl[k].led);
         chk("tbl_c", c_o[0], tbl[k].c);
         chk("tbl_frame_done", fd[0], tbl[k].fd);
      end
      bin[0] = 1'b0;

      repeat (5) tick();
      vin[0] = 1'b1;
      din[0] = 8'hA5;
      tick();
      vin[0] = 1'b0;
      din[0] = 8'hFF;
      chk("a5_ready_low", rdy[0], 0);
      while (m_n % 20 != 0) tick();
      chk("a5_ready_high", rdy[0], 1);
      tick();
      chk("a5_left", led[0], 7'h77);
      repeat (10) tick();
      chk("a5_right", led[0], 7'h6D);
      chk("a5_right_c", c_o[0], 0);

      vin[0] = 1'b1;
      din[0] = 8'h12;
      tick();
      din[0] = 8'h34;
      while (m_n % 20 != 0) tick();
      tick();
      chk("hold_left", led[0], 7'h06);
      chk("hold_ready_low", rdy[0], 0);
      vin[0] = 1'b0;
      repeat (10) tick();
      chk("hold_right", led[0], 7'h5B);
      while (m_n % 20 != 0) tick();
      tick();
      chk("hold_next_left", led[0], 7'h4F);

      vin[1] = 1'b1;
      din[1] = 8'h07;
      tick();
      vin[1] = 1'b0;
      while (m_n % 20 != 0) tick();
      tick();
      chk("bl_left", led[1], 7'h00);
      chk("bl_left_c", c_o[1], 1);
      repeat (10) tick();
      chk("bl_right", led[1], 7'h07);
      chk("bl_right_c", c_o[1], 0);

      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < 2; i++) begin
            vin[i] = $urandom_range(0, 3) == 0;
            din[i] = 8'($urandom);
            bin[i] = $urandom_range(0, 9) == 0;
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         vin[i] = 1'b0;
         bin[i] = 1'b0;
      end

      while (m_n % 20 != 1) tick();
      vin[0] = 1'b1;
      din[0] = 8'h5C;
      tick();
      vin[0] = 1'b0;
      while (m_n % 20 != 9) tick();
      chk("pend_before_reset", rdy[0], 0);
      do_reset();
      tick();
      chk("post_reset_left", led[0], 7'h3F);
      chk("post_reset_c", c_o[0], 1);
      repeat (10) tick();
      chk("post_reset_right", led[0], 7'h3F);
      repeat (20) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
